line_fill_master: RTL and testbench

LINE_FILL_MASTER -- requirements
Module: line_fill_master

---
 rtl/line_fill_master_pkg.sv | 32 +++
 rtl/line_fill_master_wrap4_addr_gen.sv | 16 +
 rtl/line_fill_master.sv | 189 ++++++++++++++++++
 tb/tb_line_fill_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_fill_master_pkg.sv
// Shared AHB fetch-side definitions: transfer/burst encodings, line-fill FSM states
// and the default line boundary mask.
package line_fill_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LINE_W = 128;

    localparam logic [ADDR_W-1:0] LINE_MASK_DEF = 32'hFFFF_FFF0;
    localparam logic [2:0]        HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } TRANS_TYPES;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_WRAP4  = 3'd3
    } BURST_TYPES;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BURST = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } FILL_STATES;

endpackage

// File: rtl/line_fill_master_wrap4_addr_gen.sv
// WRAP4 beat address: word offset advances modulo 4 so the burst never leaves the line.
module wrap4_addr_gen
    import line_fill_master_pkg::*;
(
    input  logic [ADDR_W-1:0] i_base,
    input  logic [1:0]        i_off,
    input  logic [1:0]        i_beat,
    output logic [ADDR_W-1:0] o_addr_c
);

    logic [1:0] w_word;

    assign w_word   = i_off + i_beat;
    assign o_addr_c = i_base | ADDR_W'({w_word, 2'b00});

endmodule

// File: rtl/line_fill_master.sv
// Instruction-cache line fill master: one critical-word-first AHB WRAP4 read burst per miss,
// early critical word pulse, whole-line fill pulse, abort on ERROR response.
module line_fill_master
    import line_fill_master_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LINE_MASK = LINE_MASK_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_miss_valid,
    output logic              o_miss_ready,
    input  logic [ADDR_W-1:0] i_miss_addr,
    output logic [ADDR_W-1:0] o_haddr,
    output logic [1:0]        o_htrans,
    output logic [2:0]        o_hburst,
    output logic [2:0]        o_hsize,
    output logic              o_hwrite,
    input  logic              i_hready,
    input  logic              i_hresp,
    input  logic [DATA_W-1:0] i_hrdata,
    output logic              o_crit_valid,
    output logic [DATA_W-1:0] o_crit_data,
    output logic              o_fill_valid,
    output logic [ADDR_W-1:0] o_fill_addr,
    output logic [LINE_W-1:0] o_fill_data,
    output logic              o_fill_err,
    output logic              o_busy
);

    FILL_STATES        r_state;
    TRANS_TYPES        r_htrans;
    BURST_TYPES        r_hburst;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_off;
    logic [1:0]        r_abeat;
    logic [1:0]        r_dbeat;
    logic              r_err;
    logic              r_miss_ready;
    logic [ADDR_W-1:0] r_haddr;
    logic              r_crit_valid;
    logic [DATA_W-1:0] r_crit_data;
    logic              r_fill_valid;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [LINE_W-1:0] r_line;
    logic              r_fill_err;
    logic              r_busy;

    logic [ADDR_W-1:0] w_gen_base;
    logic [1:0]        w_gen_off;
    logic [1:0]        w_gen_beat;
    logic [ADDR_W-1:0] w_gen_addr;
    logic [1:0]        w_word;
    logic              w_capture;

    // In IDLE the generator computes beat 0 of the incoming miss, otherwise the next beat.
    assign w_gen_base = (r_state == ST_IDLE) ? (i_miss_addr & LINE_MASK) : r_base;
    assign w_gen_off  = (r_state == ST_IDLE) ? i_miss_addr[3:2] : r_off;
    assign w_gen_beat = (r_state == ST_IDLE) ? 2'd0 : r_abeat + 2'd1;

    wrap4_addr_gen u_addr_gen (
        .i_base   (w_gen_base),
        .i_off    (w_gen_off),
        .i_beat   (w_gen_beat),
        .o_addr_c (w_gen_addr)
    );

    assign w_word    = r_off + r_dbeat;
    assign w_capture = (r_state == ST_BURST || (r_state == ST_DRAIN && !r_err))
                       && i_hready && !i_hresp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_htrans     <= HTRANS_IDLE;
            r_hburst     <= HBURST_SINGLE;
            r_base       <= '0;
            r_off        <= 2'd0;
            r_abeat      <= 2'd0;
            r_dbeat      <= 2'd0;
            r_err        <= 1'b0;
            r_miss_ready <= 1'b0;
            r_haddr      <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_line       <= '0;
            r_fill_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_crit_valid <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_err   <= 1'b0;

            if (w_capture) begin
                r_line[{w_word, 5'b00000} +: DATA_W] <= i_hrdata;
                if (r_dbeat == 2'd0) begin
                    r_crit_valid <= 1'b1;
                    r_crit_data  <= i_hrdata;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_miss_ready <= 1'b1;
                    if (i_miss_valid && r_miss_ready) begin
                        r_state      <= ST_ADDR;
                        r_base       <= w_gen_base;
                        r_off        <= w_gen_off;
                        r_abeat      <= 2'd0;
                        r_dbeat      <= 2'd0;
                        r_err        <= 1'b0;
                        r_miss_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_htrans     <= HTRANS_NONSEQ;
                        r_hburst     <= HBURST_WRAP4;
                        r_haddr      <= w_gen_addr;
                    end
                end
                ST_ADDR: begin
                    if (i_hready) begin
                        r_state  <= ST_BURST;
                        r_dbeat  <= 2'd0;
                        r_abeat  <= 2'd1;
                        r_haddr  <= w_gen_addr;
                        r_htrans <= HTRANS_SEQ;
                    end
                end
                ST_BURST, ST_DRAIN: begin
                    // ERROR: cancel the burst now, leave once the slave finishes the response.
                    if (i_hresp || r_err) begin
                        r_htrans <= HTRANS_IDLE;
                        if (i_hready) begin
                            r_state      <= ST_IDLE;
                            r_err        <= 1'b0;
                            r_fill_err   <= 1'b1;
                            r_busy       <= 1'b0;
                            r_hburst     <= HBURST_SINGLE;
                            r_miss_ready <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_err   <= 1'b1;
                        end
                    end else if (i_hready) begin
                        if (r_state == ST_BURST) begin
                            r_dbeat <= r_abeat;
                            if (r_abeat == 2'd3) begin
                                r_state  <= ST_DRAIN;
                                r_htrans <= HTRANS_IDLE;
                            end else begin
                                r_abeat  <= r_abeat + 2'd1;
                                r_haddr  <= w_gen_addr;
                                r_htrans <= HTRANS_SEQ;
                            end
                        end else if (r_dbeat == 2'd3) begin
                            r_state      <= ST_DONE;
                            r_fill_valid <= 1'b1;
                            r_fill_addr  <= r_base;
                        end
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_hburst     <= HBURST_SINGLE;
                    r_miss_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_miss_ready = r_miss_ready;
    assign o_haddr      = r_haddr;
    assign o_htrans     = r_htrans;
    assign o_hburst     = r_hburst;
    assign o_hsize      = HSIZE_WORD;
    assign o_hwrite     = 1'b0;
    assign o_crit_valid = r_crit_valid;
    assign o_crit_data  = r_crit_data;
    assign o_fill_valid = r_fill_valid;
    assign o_fill_addr  = r_fill_addr;
    assign o_fill_data  = r_line;
    assign o_fill_err   = r_fill_err;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_line_fill_master.sv
// Directed bench for line_fill_master: wrap order, wait states, ERROR abort,
// ignored second miss and reset mid-burst.
module tb_line_fill_master;
    import line_fill_master_pkg::*;

    logic          clk = 1'b0;
    logic          rstn;
    logic          miss_valid;
    logic          miss_ready;
    logic [31:0]   miss_addr;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic [2:0]    hsize;
    logic          hwrite;
    logic          hready;
    logic          hresp;
    logic [31:0]   hrdata;
    logic          crit_valid;
    logic [31:0]   crit_data;
    logic          fill_valid;
    logic [31:0]   fill_addr;
    logic [127:0]  fill_data;
    logic          fill_err;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    line_fill_master dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_miss_valid (miss_valid),
        .o_miss_ready (miss_ready),
        .i_miss_addr  (miss_addr),
        .o_haddr      (haddr),
        .o_htrans     (htrans),
        .o_hburst     (hburst),
        .o_hsize      (hsize),
        .o_hwrite     (hwrite),
        .i_hready     (hready),
        .i_hresp      (hresp),
        .i_hrdata     (hrdata),
        .o_crit_valid (crit_valid),
        .o_crit_data  (crit_data),
        .o_fill_valid (fill_valid),
        .o_fill_addr  (fill_addr),
        .o_fill_data  (fill_data),
        .o_fill_err   (fill_err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; miss_valid = 1'b0; miss_addr = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        step(); step();
        chk("rst_miss_ready", miss_ready, 0);
        chk("rst_htrans", htrans, 0);
        chk("rst_hburst", hburst, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_outputs", {crit_valid, fill_valid, fill_err, busy}, 0);
        chk("rst_fill_data", fill_data, 0);
        rstn = 1'b1;
        chk("rel_miss_ready_lo", miss_ready, 0);
        step();
        chk("rel_miss_ready_hi", miss_ready, 1);

        // Miss 0x1008, no wait states
        miss_valid = 1'b1; miss_addr = 32'h0000_1008;
        step();
        miss_valid = 1'b0;
        chk("t1_c1_htrans", htrans, 2);
        chk("t1_c1_haddr", haddr, 32'h1008);
        chk("t1_c1_hburst", hburst, 3);
        chk("t1_c1_hsize_hwrite", {hsize, hwrite}, 4'b0100);
        chk("t1_c1_busy_ready", {busy, miss_ready}, 2'b10);
        step();
        chk("t1_c2_htrans", htrans, 3);
        chk("t1_c2_haddr", haddr, 32'h100C);
        hrdata = 32'hA0;
        step();
        chk("t1_c3_crit_valid", crit_valid, 1);
        chk("t1_c3_crit_data", crit_data, 32'hA0);
        chk("t1_c3_haddr", haddr, 32'h1000);
        hrdata = 32'hA1;
        step();
        chk("t1_c4_haddr", haddr, 32'h1004);
        chk("t1_c4_crit_valid", crit_valid, 0);
        hrdata = 32'hA2;
        step();
        chk("t1_c5_htrans", htrans, 0);
        chk("t1_c5_haddr", haddr, 32'h1004);
        chk("t1_c5_fill_valid", fill_valid, 0);
        hrdata = 32'hA3;
        step();
        chk("t1_c6_fill_valid", fill_valid, 1);
        chk("t1_c6_fill_addr", fill_addr, 32'h1000);
        chk("t1_c6_fill_data", fill_data, {32'hA1, 32'hA0, 32'hA3, 32'hA2});
        chk("t1_c6_busy_ready", {busy, miss_ready}, 2'b10);
        step();
        chk("t1_c7_fill_valid", fill_valid, 0);
        chk("t1_c7_busy_ready", {busy, miss_ready}, 2'b01);
        chk("t1_c7_hburst", hburst, 0);

        // Miss 0x2000, two wait states on beat 1 address / beat 0 data
        miss_valid = 1'b1; miss_addr = 32'h0000_2000;
        step();
        miss_valid = 1'b0;
        chk("t2_c1_haddr", haddr, 32'h2000);
        step();
        chk("t2_c2_haddr", haddr, 32'h2004);
        hready = 1'b0; hrdata = 32'hDEAD_BEEF;
        step();
        chk("t2_c3_haddr", haddr, 32'h2004);
        chk("t2_c3_htrans", htrans, 3);
        chk("t2_c3_crit_valid", crit_valid, 0);
        step();
        chk("t2_c4_haddr", haddr, 32'h2004);
        chk("t2_c4_crit_valid", crit_valid, 0);
        hready = 1'b1; hrdata = 32'hB0;
        step();
        chk("t2_c5_crit", {crit_valid, crit_data}, {1'b1, 32'hB0});
        chk("t2_c5_haddr", haddr, 32'h2008);
        hrdata = 32'hB1;
        step();
        chk("t2_c6_haddr", haddr, 32'h200C);
        hrdata = 32'hB2;
        step();
        chk("t2_c7_htrans", htrans, 0);
        chk("t2_c7_fill_valid", fill_valid, 0);
        hrdata = 32'hB3;
        step();
        chk("t2_c8_fill_valid", fill_valid, 1);
        chk("t2_c8_fill_addr", fill_addr, 32'h2000);
        chk("t2_c8_fill_data", fill_data, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        step();
        chk("t2_c9_fill_valid", fill_valid, 0);

        // Miss 0x300C, ERROR on beat 2 data phase
        miss_valid = 1'b1; miss_addr = 32'h0000_300C;
        step();
        miss_valid = 1'b0;
        chk("t3_c1_haddr", haddr, 32'h300C);
        step();
        chk("t3_c2_haddr", haddr, 32'h3000);
        hrdata = 32'hC0;
        step();
        chk("t3_c3_crit", {crit_valid, crit_data}, {1'b1, 32'hC0});
        chk("t3_c3_haddr", haddr, 32'h3004);
        hrdata = 32'hC1;
        step();
        chk("t3_c4_haddr", haddr, 32'h3008);
        hrdata = 32'hC2; hresp = 1'b1; hready = 1'b0;
        step();
        chk("t3_c5_htrans", htrans, 0);
        chk("t3_c5_busy_err", {busy, fill_err}, 2'b10);
        hready = 1'b1;
        step();
        hresp = 1'b0;
        chk("t3_c6_fill_err", fill_err, 1);
        chk("t3_c6_no_fill", {fill_valid, crit_valid}, 2'b00);
        chk("t3_c6_busy_ready", {busy, miss_ready}, 2'b01);
        step();
        chk("t3_c7_pulses", {fill_err, fill_valid}, 2'b00);

        // Miss 0x5000 with a second request held high throughout the burst
        miss_valid = 1'b1; miss_addr = 32'h0000_5000;
        step();
        miss_addr = 32'h0000_6000;
        chk("t4_c1_ready", miss_ready, 0);
        chk("t4_c1_haddr", haddr, 32'h5000);
        step();
        chk("t4_c2_ready", miss_ready, 0);
        chk("t4_c2_haddr", haddr, 32'h5004);
        hrdata = 32'hF0;
        step();
        chk("t4_c3_crit_data", crit_data, 32'hF0);
        hrdata = 32'hF1;
        step();
        hrdata = 32'hF2;
        step();
        chk("t4_c5_ready", miss_ready, 0);
        hrdata = 32'hF3;
        step();
        chk("t4_c6_fill", {fill_valid, fill_addr}, {1'b1, 32'h5000});
        chk("t4_c6_ready", miss_ready, 0);
        chk("t4_c6_fill_data", fill_data, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
        step();
        chk("t4_c7_busy_ready", {busy, miss_ready}, 2'b01);
        step();
        miss_valid = 1'b0;
        chk("t4_c8_second_addr", {htrans, haddr}, {2'd2, 32'h6000});
        chk("t4_c8_busy", busy, 1);
        step();
        hrdata = 32'h10;
        step();
        hrdata = 32'h11;
        step();
        hrdata = 32'h12;
        step();
        hrdata = 32'h13;
        step();
        chk("t4_c13_fill", {fill_valid, fill_addr}, {1'b1, 32'h6000});
        chk("t4_c13_fill_data", fill_data, {32'h13, 32'h12, 32'h11, 32'h10});
        step();

        // Miss 0x4004, reset asserted during BURST
        miss_valid = 1'b1; miss_addr = 32'h0000_4004;
        step();
        miss_valid = 1'b0;
        chk("t5_c1_haddr", haddr, 32'h4004);
        step();
        chk("t5_c2_haddr", haddr, 32'h4008);
        hrdata = 32'hE0;
        step();
        chk("t5_c3_crit", {crit_valid, crit_data}, {1'b1, 32'hE0});
        hrdata = 32'hE1;
        rstn = 1'b0;
        #1;
        chk("t5_rst_htrans_haddr", {htrans, haddr}, {2'd0, 32'h0});
        chk("t5_rst_flags", {busy, crit_valid, fill_valid, fill_err, miss_ready}, 0);
        chk("t5_rst_hburst", hburst, 0);
        chk("t5_rst_data", {crit_data, fill_addr, fill_data}, 0);
        step(); step();
        rstn = 1'b1;
        chk("t5_rel_ready_lo", miss_ready, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_pulse", {fill_valid, fill_err, busy}, 3'b000);
        end
        chk("t5_ready_hi", miss_ready, 1);
        miss_valid = 1'b1; miss_addr = 32'h0000_7010;
        step();
        miss_valid = 1'b0;
        chk("t6_c1_addr", {htrans, haddr}, {2'd2, 32'h7010});
        step();
        hrdata = 32'h20;
        step();
        chk("t6_c3_crit", {crit_valid, crit_data}, {1'b1, 32'h20});
        hrdata = 32'h21;
        step();
        hrdata = 32'h22;
        step();
        hrdata = 32'h23;
        step();
        chk("t6_c6_fill", {fill_valid, fill_addr}, {1'b1, 32'h7010});
        chk("t6_c6_fill_data", fill_data, {32'h23, 32'h22, 32'h21, 32'h20});
        step();
        chk("t6_c7_idle", {fill_valid, busy, miss_ready}, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
